// File: rtl/fifo_stim_driver_pkg.sv
// rtl/fifo_stim_driver_pkg.sv - shared types, LFSR taps and helpers for the FIFO stimulus driver
package fifo_stim_driver_pkg;

    typedef enum logic [1:0] {IDLE, RST_FIFO, RUN, DONE} stim_state_e;
    typedef enum logic [1:0] {M_RAND, M_WR, M_RD, M_ALT} stim_mode_e;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Percent -> threshold against a 7-bit random field; 100% yields 128 so the compare is always true
    function automatic logic [7:0] pct_threshold(input int unsigned pct);
        return 8'((pct * 128) / 100);
    endfunction

endpackage

// File: rtl/fifo_stim_driver_if.sv
// rtl/fifo_stim_driver_if.sv - driver-side FIFO signal bundle
// master: drives fifo_rst_n/data_in/wr_en/rd_en, observes full/empty
// slave : the FIFO side (or a bench standing in for it)
interface fifo_stim_driver_if #(
    parameter int unsigned FIFO_WIDTH = 16
) ();
    logic                  fifo_rst_n;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic                  full;
    logic                  empty;

    modport master (output fifo_rst_n, data_in, wr_en, rd_en, input full, empty);
    modport slave  (input fifo_rst_n, data_in, wr_en, rd_en, output full, empty);
endinterface

// File: rtl/fifo_stim_lfsr.sv
// rtl/fifo_stim_lfsr.sv - 32-bit Galois LFSR with synchronous load and step enable
// Ports: clk, rst_n (sync, active-low), load_i (reload SEED), en_i (advance one step),
//        lfsr_d_o (value the register takes at the next edge)
module fifo_stim_lfsr
    import fifo_stim_driver_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        en_i,
    output logic [31:0] lfsr_d_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Exposing the next value lets the top register a beat in the same edge the LFSR moves
    assign lfsr_d_o = lfsr_d;

endmodule

// File: rtl/fifo_stim_driver.sv
// rtl/fifo_stim_driver.sv - LFSR-based stimulus source driving a FIFO's write/read side
// Ports: clk, rst_n (sync, active-low), start (pulse), mode, respect_flags,
//        fifo (master modport: fifo_rst_n, data_in, wr_en, rd_en out; full, empty in),
//        busy, done, txn_count (RUN beats issued)
module fifo_stim_driver
    import fifo_stim_driver_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned NUM_TXN    = 1000,
    parameter int unsigned WR_ON_PCT  = 70,
    parameter int unsigned RD_ON_PCT  = 30,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 respect_flags,
    fifo_stim_driver_if.master   fifo,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          txn_count
);

    localparam logic [7:0]  WR_TH    = pct_threshold(WR_ON_PCT);
    localparam logic [7:0]  RD_TH    = pct_threshold(RD_ON_PCT);
    localparam logic [31:0] LAST_TXN = 32'(NUM_TXN - 1);

    stim_state_e state_q, state_d;
    stim_mode_e  mode_q, mode_d;
    logic        respect_q, respect_d;
    logic        rst_cnt_q, rst_cnt_d;
    logic [31:0] count_q, count_d;
    logic        start_acc;
    logic        lfsr_en;
    logic [31:0] lfsr_d;

    logic                  fifo_rst_n_q, fifo_rst_n_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_beat, rd_beat;

    fifo_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (start_acc),
        .en_i     (lfsr_en),
        .lfsr_d_o (lfsr_d)
    );

    // Only some LFSR bits feed the enables and data; the rest are intentionally dropped
    logic unused_lfsr;
    assign unused_lfsr = &{1'b0, lfsr_d};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= M_RAND;
            respect_q    <= 1'b0;
            rst_cnt_q    <= 1'b0;
            count_q      <= 32'd0;
            fifo_rst_n_q <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            respect_q    <= respect_d;
            rst_cnt_q    <= rst_cnt_d;
            count_q      <= count_d;
            fifo_rst_n_q <= fifo_rst_n_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        respect_d = respect_q;
        rst_cnt_d = rst_cnt_q;
        count_d   = count_q;
        start_acc = start && ((state_q == IDLE) || (state_q == DONE));
        lfsr_en   = (state_q == RUN);

        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_d   = RST_FIFO;
                    mode_d    = stim_mode_e'(mode);
                    respect_d = respect_flags;
                    rst_cnt_d = 1'b0;
                end
            end
            RST_FIFO: begin
                if (rst_cnt_q) state_d = RUN;
                else           rst_cnt_d = 1'b1;
            end
            RUN: begin
                if (count_q == LAST_TXN) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (start_acc) begin
            count_d = 32'd0;
        end else if ((state_q == RUN) && (count_q != 32'(NUM_TXN))) begin
            count_d = count_q + 32'd1;
        end
    end

    // The registered outputs show beat k while txn_count reads k, so the beat is built from
    // the next-edge LFSR value and count.
    always_comb begin
        wr_beat = 1'b0;
        rd_beat = 1'b0;
        case (mode_q)
            M_RAND: begin
                wr_beat = ({1'b0, lfsr_d[31:25]} < WR_TH);
                rd_beat = ({1'b0, lfsr_d[24:18]} < RD_TH);
            end
            M_WR:    wr_beat = 1'b1;
            M_RD:    rd_beat = 1'b1;
            default: begin
                wr_beat = ~count_d[0];
                rd_beat = count_d[0];
            end
        endcase
        if (respect_q) begin
            wr_beat = wr_beat & ~fifo.full;
            rd_beat = rd_beat & ~fifo.empty;
        end

        fifo_rst_n_d = (state_d == RUN) || (state_d == DONE);
        busy_d       = (state_d == RST_FIFO) || (state_d == RUN);
        done_d       = (state_d == DONE);
        wr_en_d      = (state_d == RUN) && wr_beat;
        rd_en_d      = (state_d == RUN) && rd_beat;
        data_d       = (state_d == RUN) ? lfsr_d[FIFO_WIDTH-1:0] : '0;
    end

    assign fifo.fifo_rst_n = fifo_rst_n_q;
    assign fifo.wr_en      = wr_en_q;
    assign fifo.rd_en      = rd_en_q;
    assign fifo.data_in    = data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign txn_count       = count_q;

endmodule
